// File: rtl/vram_text_arbiter_if.sv
// Bundled display-fetch, CPU MMIO, clear-control and VRAM macro signals of the text VRAM arbiter.
// master = requesters plus the VRAM macro, slave = the arbiter itself.
interface vram_text_arbiter_if #(
   parameter int AW = 12
);
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_gnt;
   logic          disp_rvalid;
   logic [7:0]    disp_rdata;
   logic          cpu_valid;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_ready;
   logic          cpu_rvalid;
   logic [7:0]    cpu_rdata;
   logic          clr_start;
   logic          clr_busy;
   logic          oob_err;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   modport master (
      output disp_req, disp_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
      input  disp_gnt, disp_rvalid, disp_rdata, cpu_ready, cpu_rvalid, cpu_rdata,
             clr_busy, oob_err, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  disp_req, disp_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
      output disp_gnt, disp_rvalid, disp_rdata, cpu_ready, cpu_rvalid, cpu_rdata,
             clr_busy, oob_err, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vram_text_arbiter.sv
// Single-port text VRAM arbiter: display > CPU (streak-limited) > background clear engine.
// Define VRAM_ARB_STATS_EN to add saturating stall counters stat_cpu_stall / stat_disp_stall.
module vram_text_arbiter #(
   parameter int         CELLS      = 2400,
   parameter int         AW         = 12,
   parameter int         MAX_STREAK = 4,
   parameter logic [7:0] FILL_CHAR  = 8'h20
) (
   input  logic                 clk,
   input  logic                 rst,
   vram_text_arbiter_if.slave   bus
`ifdef VRAM_ARB_STATS_EN
   ,
   output logic [15:0]          stat_cpu_stall,
   output logic [15:0]          stat_disp_stall
`endif
);

   localparam int            SW         = $clog2(MAX_STREAK + 1);
   localparam logic [AW-1:0] LAST_CELL  = AW'(CELLS - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   typedef enum logic       {S_IDLE, S_CLEAR} state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU, OWN_FILL} own_e;

   state_e        state_q, state_d;
   own_e          own_q, own_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] streak_q, streak_d;

   logic          disp_gnt, cpu_gnt, clr_gnt, in_range;

   assign in_range = (bus.cpu_addr <= LAST_CELL);

   always_comb begin
      disp_gnt      = 1'b0;
      cpu_gnt       = 1'b0;
      clr_gnt       = 1'b0;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.oob_err   = 1'b0;
      own_d         = OWN_NONE;
      state_d       = state_q;
      ptr_d         = ptr_q;
      streak_d      = streak_q;
      if (!rst) begin
         // Display yields for exactly one cycle once the CPU has waited MAX_STREAK grants.
         if (bus.disp_req && !(bus.cpu_valid && streak_q == STREAK_MAX)) begin
            disp_gnt     = 1'b1;
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.disp_addr;
            own_d        = OWN_DISP;
         end else if (bus.cpu_valid) begin
            cpu_gnt = 1'b1;
            if (in_range) begin
               bus.ram_en    = 1'b1;
               bus.ram_we    = bus.cpu_we;
               bus.ram_addr  = bus.cpu_addr;
               bus.ram_wdata = bus.cpu_wdata;
               if (!bus.cpu_we) own_d = OWN_CPU;
            end else begin
               bus.oob_err = 1'b1;
               if (!bus.cpu_we) own_d = OWN_FILL;
            end
         end else if (state_q == S_CLEAR) begin
            clr_gnt       = 1'b1;
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = ptr_q;
            bus.ram_wdata = FILL_CHAR;
         end

         if (!bus.cpu_valid || cpu_gnt)
            streak_d = '0;
         else if (disp_gnt && streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);

         case (state_q)
            S_IDLE: begin
               if (bus.clr_start) begin
                  state_d = S_CLEAR;
                  ptr_d   = '0;
               end
            end
            S_CLEAR: begin
               if (bus.clr_start)
                  ptr_d = '0;
               else if (clr_gnt) begin
                  if (ptr_q == LAST_CELL) state_d = S_IDLE;
                  else                    ptr_d   = ptr_q + AW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         own_q    <= OWN_NONE;
         ptr_q    <= '0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         own_q    <= own_d;
         ptr_q    <= ptr_d;
         streak_q <= streak_d;
      end
   end

   // Registered state is masked during reset so every output reads 0 in that cycle.
   assign bus.disp_gnt    = disp_gnt;
   assign bus.cpu_ready   = cpu_gnt;
   assign bus.clr_busy    = !rst && (state_q == S_CLEAR);
   assign bus.disp_rvalid = !rst && (own_q == OWN_DISP);
   assign bus.disp_rdata  = bus.disp_rvalid ? bus.ram_rdata : 8'h00;
   assign bus.cpu_rvalid  = !rst && (own_q == OWN_CPU || own_q == OWN_FILL);
   assign bus.cpu_rdata   = rst                ? 8'h00         :
                            (own_q == OWN_CPU)  ? bus.ram_rdata :
                            (own_q == OWN_FILL) ? FILL_CHAR     : 8'h00;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] cpu_stall_q, disp_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_stall_q  <= '0;
         disp_stall_q <= '0;
      end else begin
         if (bus.cpu_valid && !cpu_gnt && cpu_stall_q != 16'hFFFF)
            cpu_stall_q <= cpu_stall_q + 16'd1;
         if (bus.disp_req && !disp_gnt && disp_stall_q != 16'hFFFF)
            disp_stall_q <= disp_stall_q + 16'd1;
      end
   end

   assign stat_cpu_stall  = cpu_stall_q;
   assign stat_disp_stall = disp_stall_q;
`endif

endmodule

// File: tb/tb_vram_text_arbiter.sv
// Scoreboard bench for vram_text_arbiter: behavioural VRAM, reference memory image and
// per-port queues of expected read returns (data plus due cycle).
module tb_vram_text_arbiter;
   localparam int         CELLS = 2400;
   localparam int         AW    = 12;
   localparam logic [7:0] FILL  = 8'h20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vram_text_arbiter_if #(.AW(AW)) bus ();

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stat_cpu_stall, stat_disp_stall;
`endif

   vram_text_arbiter #(.CELLS(CELLS), .AW(AW), .MAX_STREAK(4), .FILL_CHAR(FILL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef VRAM_ARB_STATS_EN
      ,
      .stat_cpu_stall  (stat_cpu_stall),
      .stat_disp_stall (stat_disp_stall)
`endif
   );

   // Behavioural single-port VRAM with 1-cycle read latency.
   logic [7:0] mem [0:4095];
   logic [7:0] rd_q;
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else            rd_q <= mem[bus.ram_addr];
      end
   end
   assign bus.ram_rdata = rd_q;

   typedef struct {
      logic [7:0] d;
      int         due;
      bit         cmp;
   } exp_t;

   exp_t       cq[$];
   exp_t       dq[$];
   logic [7:0] ref_mem [0:4095];
   bit         dchk;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Return-port scoreboard: pops on rvalid, pushes on observed grants.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         cq.delete();
         dq.delete();
      end
      chk("rv_exclusive", bus.disp_rvalid & bus.cpu_rvalid, 1'b0);
      if (bus.disp_rvalid) begin
         if (dq.size() == 0) chk("disp_rv_spurious", bus.disp_rvalid, 1'b0);
         else begin
            e = dq.pop_front();
            chk("disp_rv_latency", cyc, e.due);
            if (e.cmp) chk("disp_rdata", bus.disp_rdata, e.d);
         end
      end
      if (bus.cpu_rvalid) begin
         if (cq.size() == 0) chk("cpu_rv_spurious", bus.cpu_rvalid, 1'b0);
         else begin
            e = cq.pop_front();
            chk("cpu_rv_latency", cyc, e.due);
            if (e.cmp) chk("cpu_rdata", bus.cpu_rdata, e.d);
         end
      end
      if (!rst) begin
         if (bus.disp_gnt)
            dq.push_back('{d: ref_mem[bus.disp_addr], due: cyc + 1, cmp: dchk});
         if (bus.cpu_ready && !bus.cpu_we)
            cq.push_back('{d: (int'(bus.cpu_addr) < CELLS) ? ref_mem[bus.cpu_addr] : FILL,
                           due: cyc + 1, cmp: 1'b1});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_acc(input logic we, input int addr, input logic [7:0] wd,
                          output int waited, output logic oob, output logic en);
      bus.cpu_valid = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = AW'(addr);
      bus.cpu_wdata = wd;
      waited = 0;
      oob = 1'b0;
      en  = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.cpu_ready) break;
         waited++;
         if (waited > 100) begin
            chk("cpu_ready_timeout", waited, 0);
            break;
         end
         step();
      end
      oob = bus.oob_err;
      en  = bus.ram_en;
      if (bus.cpu_ready && we && addr < CELLS) ref_mem[addr] = wd;
      step();
      bus.cpu_valid = 1'b0;
   endtask

   task automatic streak_run(input int n);
      bus.disp_req  = 1'b1;
      bus.disp_addr = AW'(5);
      bus.cpu_valid = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("streak_cpu_ready", bus.cpu_ready, (i % 5) == 4);
         chk("streak_disp_gnt", bus.disp_gnt, (i % 5) != 4);
         step();
      end
      bus.disp_req  = 1'b0;
      bus.cpu_valid = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_disp_gnt"}, bus.disp_gnt, 1'b0);
      chk({tag, "_cpu_ready"}, bus.cpu_ready, 1'b0);
      chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 1'b0);
      chk({tag, "_disp_rvalid"}, bus.disp_rvalid, 1'b0);
      chk({tag, "_rdata"}, {bus.cpu_rdata, bus.disp_rdata}, 16'h0);
      chk({tag, "_ram"}, {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);
      chk({tag, "_clr_oob"}, {bus.clr_busy, bus.oob_err}, 2'b00);
   endtask

   task automatic clear_pass(input bit rnd_disp, output int busy_n, output int gnt_n, output int late_n);
      busy_n = 0;
      gnt_n  = 0;
      late_n = 0;
      bus.clr_start = 1'b1;
      step();
      bus.clr_start = 1'b0;
      forever begin
         if (rnd_disp) begin
            bus.disp_req  = 1'($urandom_range(0, 1));
            bus.disp_addr = AW'($urandom_range(0, CELLS - 1));
         end
         @(negedge clk);
         if (!bus.clr_busy) break;
         busy_n++;
         if (bus.disp_gnt) gnt_n++;
         if (bus.disp_gnt != bus.disp_req) late_n++;
         if (busy_n > 6000) begin
            chk("clear_timeout", busy_n, 0);
            break;
         end
         step();
      end
      bus.disp_req = 1'b0;
      step();
      for (int a = 0; a < CELLS; a++) ref_mem[a] = FILL;
   endtask

   initial begin
      int   w, busy_n, gnt_n, late_n;
      logic oob, en;
      rst           = 1'b1;
      dchk          = 1'b1;
      bus.disp_req  = 1'b1;
      bus.disp_addr = '0;
      bus.cpu_valid = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.clr_start = 1'b0;
      step();
      step();
      @(negedge clk);
      chk_quiet("reset");
      step();
      bus.disp_req  = 1'b0;
      bus.cpu_valid = 1'b0;
      rst           = 1'b0;
      step();

      // Basic write then read-back, no display traffic
      cpu_acc(1'b1, 0, 8'h56, w, oob, en);
      chk("wr_ready_wait", w, 0);
      chk("wr_ram_en", en, 1'b1);
      chk("wr_oob", oob, 1'b0);
      cpu_acc(1'b0, 0, 8'h00, w, oob, en);
      chk("rd_ready_wait", w, 0);
      step();

      // Out-of-range read and write
      cpu_acc(1'b0, CELLS, 8'h00, w, oob, en);
      chk("oob_rd_wait", w, 0);
      chk("oob_rd_err", oob, 1'b1);
      chk("oob_rd_ram_en", en, 1'b0);
      cpu_acc(1'b1, CELLS, 8'h77, w, oob, en);
      chk("oob_wr_err", oob, 1'b1);
      chk("oob_wr_ram_en", en, 1'b0);
      cpu_acc(1'b0, 0, 8'h00, w, oob, en);
      chk("post_oob_err", oob, 1'b0);
      step();

      // Quiet clear pass and full read-back
      clear_pass(1'b0, busy_n, gnt_n, late_n);
      chk("clear_busy_cycles", busy_n, CELLS);
      for (int a = 0; a < CELLS; a++) cpu_acc(1'b0, a, 8'h00, w, oob, en);
      step();

      // Display/CPU streak limit
      cpu_acc(1'b1, 5, 8'h41, w, oob, en);
      cpu_acc(1'b1, 0, 8'h56, w, oob, en);
      streak_run(15);
      step();

      // Clear pass under random display traffic
      dchk = 1'b0;
      clear_pass(1'b1, busy_n, gnt_n, late_n);
      dchk = 1'b1;
      chk("clear_disp_delayed", late_n, 0);
      chk("clear_busy_vs_gnt", busy_n, CELLS + gnt_n);
      for (int a = 0; a < 8; a++) cpu_acc(1'b0, a * 300 + 7, 8'h00, w, oob, en);
      step();

      // Reset the cycle after a CPU read grant, mid-clear
      bus.clr_start = 1'b1;
      step();
      bus.clr_start = 1'b0;
      repeat (10) step();
      bus.cpu_valid = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = AW'(3);
      @(negedge clk);
      chk("rst_pre_ready", bus.cpu_ready, 1'b1);
      step();
      bus.cpu_valid = 1'b0;
      bus.disp_req  = 1'b1;
      rst           = 1'b1;
      @(negedge clk);
      chk_quiet("midrst");
      step();
      rst          = 1'b0;
      bus.disp_req = 1'b0;
      @(negedge clk);
      chk("post_rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
      chk("post_rst_clr_busy", bus.clr_busy, 1'b0);
      step();
      streak_run(10);
      step();
      step();

      chk("cpu_queue_empty", cq.size(), 0);
      chk("disp_queue_empty", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
